// File: rtl/riscv_pkg.sv
// Shared core constants and small helpers for the writeback path.
package riscv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NREG     = 1 << REG_AW;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // Increment an index modulo n without relying on a power-of-two n.
  function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating pointer.
module rr_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N-1:0]                      req,
  input  logic                              advance,
  output logic [N-1:0]                      grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gidx
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr;

  // Scan from the pointer, wrapping, and pick the first valid requester.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant = '0;
    gidx  = '0;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = IW'(idx);
        found      = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner after each transfer, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= IW'(wrap_inc(32'(gidx), N));
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port among writeback units and tracks busy destinations.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned AW   = riscv_pkg::REG_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_a3,
  output logic [XLEN-1:0]      rf_wd3,
  output logic [(1<<AW)-1:0]   busy,
  output logic                 err_waw
);

  localparam int unsigned NREG = 1 << AW;
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic            xfer;
  logic [AW-1:0]   win_addr;
  logic [XLEN-1:0] win_data;
  logic [NREG-1:0] busy_next;
  logic            waw_hit;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (xfer),
    .grant   (grant),
    .gidx    (gidx)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  // Select the winning requester's address and data.
  always_comb begin
    win_addr = req_addr[gidx*AW +: AW];
    win_data = req_data[gidx*XLEN +: XLEN];
  end

  // Registered write port; x0 writes are accepted but never enable the regfile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we  <= 1'b0;
      rf_a3  <= '0;
      rf_wd3 <= '0;
    end else if (xfer) begin
      rf_we  <= (win_addr != '0);
      rf_a3  <= win_addr;
      rf_wd3 <= win_data;
    end else begin
      rf_we  <= 1'b0;
    end
  end

  // Scoreboard next state: clear applied before set so a new producer wins.
  always_comb begin
    busy_next = busy;
    waw_hit   = 1'b0;
    if (xfer) busy_next[win_addr] = 1'b0;
    if (iss_valid && iss_rd != '0) begin
      busy_next[iss_rd] = 1'b1;
      waw_hit = busy[iss_rd] && !(xfer && win_addr == iss_rd);
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard and sticky WAW error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= '0;
      err_waw <= 1'b0;
    end else begin
      busy <= busy_next;
      if (waw_hit) err_waw <= 1'b1;
    end
  end

endmodule
